pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 104 ++++++++++
 tb/tb_pipeline_control.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control.sv
// Hazard and stall controller for a 5-stage pipeline: load-use bubbles,
// taken-branch flushes, memory wait with sticky timeout, and a stall-cycle counter.
module pipeline_control #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        exMemRead,
    input  logic [4:0]  exRt,
    input  logic        branchTaken,
    input  logic        memBusy,
    output logic        pcEnable,
    output logic        ifIdEnable,
    output logic        pipeEnable,
    output logic        ifIdFlush,
    output logic        idExFlush,
    output logic [1:0]  state,
    output logic [15:0] stallCount,
    output logic        memTimeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);

    state_t     cur_state;
    state_t     nxt_state;
    logic [1:0] flush_cnt;
    logic [1:0] flush_nxt;
    logic [7:0] busy_cnt;
    logic       load_use;

    assign load_use = exMemRead && (exRt != 5'd0) && ((exRt == idRs) || (exRt == idRt));
    assign state    = cur_state;

    always_comb begin
        pcEnable   = 1'b1;
        ifIdEnable = 1'b1;
        pipeEnable = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        nxt_state  = cur_state;
        flush_nxt  = flush_cnt;
        if (!rst_n) begin
            nxt_state = RUN;
        end else if (memBusy) begin
            pcEnable   = 1'b0;
            ifIdEnable = 1'b0;
            pipeEnable = 1'b0;
            nxt_state  = MEM_WAIT;
        end else if (branchTaken) begin
            // Same outputs whether the branch resolves in RUN, FLUSH or on MEM_WAIT exit
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
            flush_nxt = FLUSH_RELOAD;
            nxt_state = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (cur_state == FLUSH) begin
            ifIdFlush = 1'b1;
            flush_nxt = flush_cnt - 2'd1;
            nxt_state = (flush_nxt == 2'd0) ? RUN : FLUSH;
        end else begin
            if (load_use) begin
                pcEnable   = 1'b0;
                ifIdEnable = 1'b0;
                idExFlush  = 1'b1;
            end
            // A flush interrupted by memBusy resumes once the wait is over
            nxt_state = (flush_cnt != 2'd0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= RUN;
            flush_cnt  <= '0;
            busy_cnt   <= '0;
            stallCount <= '0;
            memTimeout <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            flush_cnt <= flush_nxt;
            if (memBusy && (cur_state == MEM_WAIT)) begin
                if (busy_cnt != TIMEOUT) begin
                    busy_cnt <= busy_cnt + 8'd1;
                    if ((busy_cnt + 8'd1) == TIMEOUT)
                        memTimeout <= 1'b1;
                end
            end else if (!memBusy) begin
                busy_cnt <= '0;
            end
            if ((!pcEnable || ifIdFlush || idExFlush) && (stallCount != '1))
                stallCount <= stallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed hazard scenarios followed by
// randomized traffic compared against a cycle-level behavioural model.
module tb_pipeline_control;

    localparam int FC = 3;
    localparam int MT = 4;

    logic        clk;
    logic        rst_n;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        exMemRead;
    logic [4:0]  exRt;
    logic        branchTaken;
    logic        memBusy;
    logic        pcEnable;
    logic        ifIdEnable;
    logic        pipeEnable;
    logic        ifIdFlush;
    logic        idExFlush;
    logic [1:0]  state;
    logic [15:0] stallCount;
    logic        memTimeout;

    pipeline_control #(
        .FLUSH_CYCLES(FC),
        .MEM_TIMEOUT (MT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .idRs       (idRs),
        .idRt       (idRt),
        .exMemRead  (exMemRead),
        .exRt       (exRt),
        .branchTaken(branchTaken),
        .memBusy    (memBusy),
        .pcEnable   (pcEnable),
        .ifIdEnable (ifIdEnable),
        .pipeEnable (pipeEnable),
        .ifIdFlush  (ifIdFlush),
        .idExFlush  (idExFlush),
        .state      (state),
        .stallCount (stallCount),
        .memTimeout (memTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0=RUN 1=FLUSH 2=MEM_WAIT, remaining flush cycles, busy count
    int m_state = 0;
    int m_fc    = 0;
    int m_busy  = 0;
    int m_stall = 0;
    int m_to    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [4:0] outs();
        return {pcEnable, ifIdEnable, pipeEnable, ifIdFlush, idExFlush};
    endfunction

    task automatic model_reset();
        m_state = 0; m_fc = 0; m_busy = 0; m_stall = 0; m_to = 0;
    endtask

    // Called at posedge+1: drive, check combinational outputs mid-cycle, clock, check state
    task automatic step(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] rtt, input logic br, input logic mb);
        logic [4:0] exp;
        bit lu;
        int n_state, n_fc, n_busy, n_to;
        exMemRead = mr; exRt = rt; idRs = rs; idRt = rtt; branchTaken = br; memBusy = mb;
        lu = mr && (rt != 0) && ((rt == rs) || (rt == rtt));
        n_state = m_state; n_fc = m_fc; n_busy = m_busy; n_to = m_to;
        if (mb) begin
            exp = 5'b00000;
            n_state = 2;
            if (m_state == 2) begin
                if (m_busy < MT) n_busy = m_busy + 1;
                if (n_busy >= MT) n_to = 1;
            end
        end else begin
            n_busy = 0;
            if (br) begin
                exp = 5'b11111;
                n_fc = FC - 1;
                n_state = (n_fc > 0) ? 1 : 0;
            end else if (m_state == 1) begin
                exp = 5'b11110;
                n_fc = m_fc - 1;
                n_state = (n_fc > 0) ? 1 : 0;
            end else begin
                exp = lu ? 5'b00101 : 5'b11100;
                n_state = (m_fc > 0) ? 1 : 0;
            end
        end
        #4;
        check("outputs", 32'(outs()), 32'(exp));
        if ((exp[4] == 1'b0 || exp[1] || exp[0]) && m_stall < 65535) m_stall++;
        m_state = n_state; m_fc = n_fc; m_busy = n_busy; m_to = n_to;
        @(posedge clk);
        #1;
        check("state", 32'(state), 32'(m_state));
        check("stallCount", 32'(stallCount), 32'(m_stall));
        check("memTimeout", 32'(memTimeout), 32'(m_to));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset between edges; inputs stay as they were while rst_n is low
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall", 32'(stallCount), 32'd0);
        check("rst_timeout", 32'(memTimeout), 32'd0);
        check("rst_outputs", 32'(outs()), 32'(5'b11100));
        exMemRead = 1'b0; exRt = '0; idRs = '0; idRt = '0; branchTaken = 1'b0; memBusy = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int base;
    int busy_left;

    initial begin
        rst_n = 1'b0;
        exMemRead = 1'b0; exRt = '0; idRs = '0; idRt = '0; branchTaken = 1'b0; memBusy = 1'b0;
        #2;
        check("init_state", 32'(state), 32'd0);
        check("init_stall", 32'(stallCount), 32'd0);
        check("init_outputs", 32'(outs()), 32'(5'b11100));
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use on rs
        step(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
        check("loaduse_stall", 32'(stallCount), 32'd1);
        // Load into r0 never stalls
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0);

        // Taken branch: three flush cycles in total
        base = m_stall;
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        check("branch_state1", 32'(state), 32'd1);
        idle(2);
        check("branch_back_run", 32'(state), 32'd0);
        check("branch_stalls", 32'(stallCount), 32'(base + 3));
        idle(1);

        // memBusy beats branch and load-use
        step(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
        check("prio_state", 32'(state), 32'd2);
        idle(1);

        // Busy held six cycles: timeout after the fourth in MEM_WAIT, sticky afterwards
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(2);
        check("timeout_sticky", 32'(memTimeout), 32'd1);

        // Busy interrupting a flush, then resuming it
        do_reset();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        idle(4);

        // Reset while waiting on memory
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        memBusy = 1'b1;
        do_reset();

        busy_left = 0;
        for (int c = 0; c < 3000; c++) begin
            logic mb;
            if (busy_left == 0 && $urandom_range(0, 7) == 0) busy_left = $urandom_range(1, 7);
            mb = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0), mb);
            if (c % 500 == 499) begin
                memBusy = mb;
                do_reset();
                busy_left = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
